pipe_stage_skid: RTL and testbench

//  Generic parametrised inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_perf_cnt.sv | 21 ++
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 tb/tb_pipe_stage_skid.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: stage occupancy states, perf counter width,
// and EX->MEM payload field offsets so producer, stage and consumer agree.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_st_e;

  localparam int PERF_W = 32;

  localparam int EXM_ALUOP_LSB = 0;
  localparam int EXM_ALUOP_W   = 8;
  localparam int EXM_ADDR_LSB  = 8;
  localparam int EXM_ADDR_W    = 32;
  localparam int EXM_WDATA_LSB = 40;
  localparam int EXM_WDATA_W   = 32;
  localparam int EXM_CP0_LSB   = 72;
  localparam int EXM_CP0_W     = 32;
  localparam int EXM_TRAP_LSB  = 104;
  localparam int EXM_TRAP_W    = 24;
  localparam int EXM_W         = 128;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter.
// Ports: clk, clr (sync clear), inc (count enable), cnt (current value).
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready handshake and 2-entry skid buffer,
// flush path and a scratch side-channel held while the producer is stalled.
// Ports: clk, rst (sync, high), flush; in_valid/in_data/in_ready upstream;
// out_valid/out_data/out_ready downstream; scr_i/scr_o scratch;
// perf_bub/perf_bp counters, live only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter int                SCR_W   = 66,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic [SCR_W-1:0]  scr_i,
  output logic [SCR_W-1:0]  scr_o,
  output logic [PERF_W-1:0] perf_bub,
  output logic [PERF_W-1:0] perf_bp
);

  pipe_st_e          st, st_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              accept, emit;
  logic              ld_in, ld_skid, shift;

  // in_ready depends on state only, never on out_ready
  assign in_ready  = (st != ST_FULL);
  assign out_valid = (st != ST_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VAL;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    st_nxt  = st;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    shift   = 1'b0;
    unique case (st)
      ST_EMPTY: begin
        if (accept) begin
          st_nxt = ST_ONE;
          ld_in  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !emit) begin
          st_nxt  = ST_FULL;
          ld_skid = 1'b1;
        end else if (!accept && emit) begin
          st_nxt = ST_EMPTY;
        end else if (accept && emit) begin
          ld_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (emit) begin
          st_nxt = ST_ONE;
          shift  = 1'b1;
        end
      end
      default: st_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      st <= ST_EMPTY;
    else
      st <= st_nxt;
  end

  // Payload registers need no reset: out_data is masked by out_valid
  always_ff @(posedge clk) begin
    if (ld_in)
      main_q <= in_data;
    else if (shift)
      main_q <= skid_q;
    if (ld_skid)
      skid_q <= in_data;
  end

  // Partials survive stalls and clear once the instruction advances
  always_ff @(posedge clk) begin
    if (rst || flush)
      scr_o <= '0;
    else
      scr_o <= accept ? '0 : scr_i;
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.W(PERF_W)) u_bub (
    .clk (clk),
    .clr (rst),
    .inc (!out_valid),
    .cnt (perf_bub)
  );

  pipe_perf_cnt #(.W(PERF_W)) u_bp (
    .clk (clk),
    .clr (rst),
    .inc (out_valid && !out_ready),
    .cnt (perf_bp)
  );
`else
  assign perf_bub = '0;
  assign perf_bp  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: reference queue of accepted beats,
// directed checks for stall, flush, scratch and perf counters.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 128;
  localparam int SW = 66;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] scr_i, scr_o;
  logic [31:0]   perf_bub, perf_bp;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] sb[$];

  pipe_stage_skid #(.DATA_W(DW), .SCR_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .scr_i     (scr_i),
    .scr_o     (scr_o),
    .perf_bub  (perf_bub),
    .perf_bp   (perf_bp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Negedge monitor: handshakes seen here complete at the next posedge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      logic [DW-1:0] exp_d;
      check("mon_in_ready", 128'(in_ready), 128'(sb.size() < 2));
      check("mon_out_valid", 128'(out_valid), 128'(sb.size() != 0));
      exp_d = (sb.size() != 0) ? sb[0] : '0;
      check("mon_out_data", out_data, exp_d);
      if (out_valid && out_ready && sb.size() != 0)
        void'(sb.pop_front());
      if (flush)
        sb.delete();
      else if (in_valid && in_ready)
        sb.push_back(in_data);
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    scr_i     = '0;

    // 1. reset
    step(2);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_scr_o", 128'(scr_o), 128'(0));
    check("rst_perf_bub", 128'(perf_bub), 128'(0));
    check("rst_perf_bp", 128'(perf_bp), 128'(0));
    rst = 1'b0;

    // 2. streaming, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(i);
      step();
      check("str_data", out_data, 128'(i));
      check("str_in_ready", 128'(in_ready), 128'(1));
    end
    in_valid = 1'b0;
    step();
    check("str_drain", 128'(out_valid), 128'(0));

    // 3. backpressure into skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hA;
    step();
    in_data   = 128'hB;
    step();
    in_valid  = 1'b0;
    check("bp_full_rdy", 128'(in_ready), 128'(0));
    check("bp_hold_a", out_data, 128'hA);
    step(2);
    check("bp_hold_a2", out_data, 128'hA);
    out_ready = 1'b1;
    step();
    check("bp_emit_b", out_data, 128'hB);
    check("bp_rdy_back", 128'(in_ready), 128'(1));
    step();
    check("bp_empty", 128'(out_valid), 128'(0));

    // 4. flush while full with an offered beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hA;
    step();
    in_data   = 128'hB;
    step();
    flush     = 1'b1;
    in_data   = 128'hC;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("fl_valid", 128'(out_valid), 128'(0));
    check("fl_nop", out_data, 128'(0));
    check("fl_rdy", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    step(3);
    check("fl_no_c", 128'(out_valid), 128'(0));

    // 5. scratch held while stalled, cleared on accept
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h11;
    step();
    in_data   = 128'h22;
    step();
    in_data   = 128'h33;
    scr_i     = 66'h3_1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check("scr_hold", 128'(scr_o), 128'(66'h3_1234));
    end
    out_ready = 1'b1;
    step();
    check("scr_hold_emit", 128'(scr_o), 128'(66'h3_1234));
    step();
    check("scr_clear", 128'(scr_o), 128'(0));
    in_valid = 1'b0;
    scr_i    = '0;
    step(3);
    check("scr_drain", 128'(out_valid), 128'(0));

    // 6. perf counters: 5 bubble then 3 backpressure cycles
    rst = 1'b1;
    out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
    in_valid = 1'b1;
    in_data  = 128'h55;
    step();
    in_valid = 1'b0;
    step(3);
`ifdef PIPE_STAGE_PERF_EN
    check("perf_bub", 128'(perf_bub), 128'(5));
    check("perf_bp", 128'(perf_bp), 128'(3));
`else
    check("perf_bub", 128'(perf_bub), 128'(0));
    check("perf_bp", 128'(perf_bp), 128'(0));
`endif
    out_ready = 1'b1;
    step(2);
    check("end_sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
